// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate decoder with a 2-entry output FIFO and a saturating illegal counter
//   clk, reset (async, active-low), flush (sync, drops buffered results)
//   in_valid/in_ready/in_instr   : instruction word handshake
//   out_valid/out_ready          : result handshake; head drives out_imm/out_fmt/out_illegal
//   illegal_cnt                  : saturating count of accepted illegal words
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int EW = XLEN + 4;
  logic [6:0]    op;
  logic          shift;
  logic [31:0]   i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm, w_imm, imm32;
  logic [2:0]    fmt;
  logic          ill;
  logic [EW-1:0] nw, e0, e1;
  logic [1:0]    cnt;
  logic          push, pop;
  assign op     = in_instr[6:0];
  assign shift  = in_instr[13:12] == 2'b01;
  assign i_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign b_imm  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign u_imm  = {in_instr[31:12], 12'b0};
  assign j_imm  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign sh_imm = XLEN == 64 ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
  assign w_imm  = {27'b0, in_instr[24:20]};
  // funct3 001/101 are exactly the encodings with bits [13:12] == 01
  always_comb begin
    imm32 = '0;
    fmt   = 3'd7;
    ill   = 1'b1;
    case (op)
      7'b0000011, 7'b1100111, 7'b1110011: {imm32, fmt, ill} = {i_imm, 3'd0, 1'b0};
      7'b0010011: {imm32, fmt, ill} = shift ? {sh_imm, 3'd5, XLEN == 32 && in_instr[25]} : {i_imm, 3'd0, 1'b0};
      7'b0011011: if (XLEN == 64) {imm32, fmt, ill} = shift ? {w_imm, 3'd5, in_instr[25]} : {i_imm, 3'd0, 1'b0};
      7'b0100011: {imm32, fmt, ill} = {s_imm, 3'd1, 1'b0};
      7'b1100011: {imm32, fmt, ill} = {b_imm, 3'd2, 1'b0};
      7'b0110111, 7'b0010111: {imm32, fmt, ill} = {u_imm, 3'd3, 1'b0};
      7'b1101111: {imm32, fmt, ill} = {j_imm, 3'd4, 1'b0};
      default: ;
    endcase
  end
  // every 32-bit immediate is sign-extended; shamt values have a clear top bit so this is also a zero-extend
  assign nw = {XLEN'($signed(imm32)), fmt, ill};
  assign in_ready  = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;
  assign out_imm     = out_valid ? e0[EW-1:4] : '0;
  assign out_fmt     = out_valid ? e0[3:1] : 3'd7;
  assign out_illegal = out_valid && e0[0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= 2'd0;
      e0          <= '0;
      e1          <= '0;
      illegal_cnt <= '0;
    end else begin
      cnt <= flush ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
      if (pop && cnt == 2'd2) e0 <= e1;
      else if (push && (cnt == 2'd0 || pop)) e0 <= nw;
      if (push && cnt == 2'd1 && !pop) e1 <= nw;
      if (push && nw[0] && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: checks XLEN=64 and XLEN=32/CNT_W=2 instances against a queue-based reference model
module tb_imm_gen_pipe;
  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ent_t;
  logic        clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  logic        rdy64, ov64, ill64, rdy32, ov32, ill32;
  logic [63:0] imm64;
  logic [31:0] imm32;
  logic [2:0]  fmt64, fmt32;
  logic [15:0] cnt64;
  logic [1:0]  cnt32;
  ent_t q64[$], q32[$];
  int   c64 = 0, c32 = 0, tests = 0, fails = 0;

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(ill64), .illegal_cnt(cnt64));
  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(ill32), .illegal_cnt(cnt32));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // reference decode: immediates rebuilt as signed integer arithmetic on the field values
  function automatic ent_t ref_dec(input logic [31:0] w, input int xlen);
    ent_t   e;
    longint v;
    int     op, f3;
    bit     sh;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    sh = f3 == 1 || f3 == 5;
    v = 0;
    e.fmt = 3'd7;
    e.ill = 1'b1;
    if (op == 'h03 || op == 'h67 || op == 'h73 || (op == 'h13 && !sh) || (op == 'h1b && xlen == 64 && !sh)) begin
      v = longint'(w[31:20]) - (w[31] ? 4096 : 0);
      e.fmt = 0; e.ill = 0;
    end else if (op == 'h13) begin
      v = xlen == 64 ? longint'(w[25:20]) : longint'(w[24:20]);
      e.fmt = 5; e.ill = xlen == 32 && w[25];
    end else if (op == 'h1b && xlen == 64) begin
      v = longint'(w[24:20]);
      e.fmt = 5; e.ill = w[25];
    end else if (op == 'h23) begin
      v = longint'(w[30:25]) * 32 + longint'(w[11:7]) - (w[31] ? 2048 : 0);
      e.fmt = 1; e.ill = 0;
    end else if (op == 'h63) begin
      v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
      e.fmt = 2; e.ill = 0;
    end else if (op == 'h37 || op == 'h17) begin
      v = longint'(w[31:12]) * 4096 - (w[31] ? 64'sh1_0000_0000 : 0);
      e.fmt = 3; e.ill = 0;
    end else if (op == 'h6f) begin
      v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
      e.fmt = 4; e.ill = 0;
    end
    e.imm = xlen == 32 ? {32'b0, v[31:0]} : v;
    return e;
  endfunction

  task automatic chk_all();
    ent_t h64, h32;
    h64 = q64.size() != 0 ? q64[0] : '{imm: 64'd0, fmt: 3'd7, ill: 1'b0};
    h32 = q32.size() != 0 ? q32[0] : '{imm: 64'd0, fmt: 3'd7, ill: 1'b0};
    chk("in_ready64", 64'(rdy64), 64'(q64.size() != 2));
    chk("out_valid64", 64'(ov64), 64'(q64.size() != 0));
    chk("imm64", imm64, h64.imm);
    chk("fmt64", 64'(fmt64), 64'(h64.fmt));
    chk("illegal64", 64'(ill64), 64'(h64.ill));
    chk("cnt64", 64'(cnt64), 64'(c64));
    chk("in_ready32", 64'(rdy32), 64'(q32.size() != 2));
    chk("out_valid32", 64'(ov32), 64'(q32.size() != 0));
    chk("imm32", {32'b0, imm32}, h32.imm);
    chk("fmt32", 64'(fmt32), 64'(h32.fmt));
    chk("illegal32", 64'(ill32), 64'(h32.ill));
    chk("cnt32", 64'(cnt32), 64'(c32));
  endtask

  task automatic model_edge(input bit v, input logic [31:0] w, input bit r, input bit f);
    bit a64, a32;
    ent_t e;
    a64 = v && q64.size() != 2;
    a32 = v && q32.size() != 2;
    if (r && q64.size() != 0) void'(q64.pop_front());
    if (r && q32.size() != 0) void'(q32.pop_front());
    if (f) begin
      q64.delete();
      q32.delete();
    end else begin
      if (a64) begin
        e = ref_dec(w, 64);
        q64.push_back(e);
        if (e.ill && c64 < 65535) c64++;
      end
      if (a32) begin
        e = ref_dec(w, 32);
        q32.push_back(e);
        if (e.ill && c32 < 3) c32++;
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [31:0] w, input bit r, input bit f);
    in_valid = v; in_instr = w; out_ready = r; flush = f;
    #1;
    chk_all();
    @(posedge clk);
    model_edge(v, w, r, f);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops[13] = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h1b, 7'h00, 7'h33, 7'h7f};
    logic [31:0] w;
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 12)];
    return w;
  endfunction

  initial begin
    int prev;
    @(posedge clk);
    @(negedge clk);
    chk_all();
    chk("rst_out_fmt", 64'(fmt64), 64'd7);
    reset = 1;
    cyc(1, 32'hFFF00093, 1, 0);
    chk("addi_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_fmt", 64'(fmt64), 64'd0);
    cyc(1, 32'hFE20BC23, 1, 0);
    chk("sd_imm", imm64, 64'hFFFFFFFFFFFFFFF8);
    chk("sd_fmt", 64'(fmt64), 64'd1);
    cyc(1, 32'hFE000EE3, 1, 0);
    chk("beq_imm", imm64, 64'hFFFFFFFFFFFFFFFC);
    chk("beq_fmt", 64'(fmt64), 64'd2);
    cyc(1, 32'h800000B7, 1, 0);
    chk("lui_imm", imm64, 64'hFFFFFFFF80000000);
    chk("lui_fmt", 64'(fmt64), 64'd3);
    cyc(1, 32'h03F09093, 1, 0);
    chk("slli64_imm", imm64, 64'd63);
    chk("slli64_fmt", 64'(fmt64), 64'd5);
    chk("slli64_ill", 64'(ill64), 64'd0);
    chk("slli32_ill", 64'(ill32), 64'd1);
    chk("slli32_cnt", 64'(cnt32), 64'd1);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h00100093, 0, 0);
    cyc(1, 32'h00200093, 0, 0);
    chk("bp_in_ready", 64'(rdy64), 64'd0);
    chk("bp_head1", imm64, 64'd1);
    cyc(1, 32'h00300093, 0, 0);
    chk("bp_hold", imm64, 64'd1);
    cyc(1, 32'h00300093, 1, 0);
    chk("bp_head2", imm64, 64'd2);
    cyc(1, 32'h00300093, 1, 0);
    chk("bp_head3", imm64, 64'd3);
    cyc(0, 0, 1, 0);
    chk("bp_drained", 64'(ov64), 64'd0);
    prev = c64;
    cyc(1, 32'h00100093, 0, 0);
    cyc(1, 32'h00200093, 0, 0);
    cyc(1, 32'h00000000, 0, 1);
    chk("flush2_valid", 64'(ov64), 64'd0);
    chk("flush2_ready", 64'(rdy64), 64'd1);
    cyc(1, 32'h00100093, 0, 0);
    cyc(1, 32'h00000000, 0, 1);
    chk("flush1_valid", 64'(ov64), 64'd0);
    chk("flush1_cnt", 64'(cnt64), 64'(prev));
    cyc(1, 32'h00000000, 0, 0);
    cyc(1, 32'hFFF00093, 0, 0);
    #2 reset = 0;
    q64.delete(); q32.delete(); c64 = 0; c32 = 0;
    #1 chk_all();
    chk("arst_fmt", 64'(fmt32), 64'd7);
    @(negedge clk);
    chk_all();
    reset = 1;
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 32'h00000000, 1, 0);
      chk("sat_cnt32", 64'(cnt32), 64'(k > 3 ? 3 : k));
      chk("sat_fmt32", 64'(fmt32), 64'd7);
    end
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk_all();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
